// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage controller. It sits after the EX/MEM register and
// drives a req/ack data-memory port. It stalls the front of the pipeline while
// an access is outstanding, and it loads the MEM/WB register for writeback.
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, any load or store
// whose address has a nonzero ex_data[2:0] is rejected without a request, and
// the sticky align_fault flag is raised.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [DATA_W-1:0] store_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [4:0]        reg_write_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_mem,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_RegWrite,
  output logic [4:0]        wb_addr,
  output logic              mem_fault,
  output logic              align_fault
);

  // The counter must be able to reach TIMEOUT_CYCLES-1. A value of 0 turns
  // the timeout off.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic              done;       // one-cycle completion marker for the current op
  logic              fault_op;   // the op that just completed must not write back
  logic [DATA_W-1:0] rdata_cap;
  logic [CNT_W-1:0]  cnt;
  logic              mem_op;
  logic              misaligned;

  // A load and a store together count as a store, because dmem_we follows MemWrite.
  assign mem_op    = MemRead | MemWrite;
  assign stall_mem = mem_op & ~done;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (ex_data[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  // Access FSM: issue the request, hold it until ack or timeout, then mark the op done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      done       <= 1'b0;
      fault_op   <= 1'b0;
      rdata_cap  <= '0;
      cnt        <= '0;
      mem_fault  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (stall_mem) begin
            if (misaligned) begin
              // Reject the op without touching memory. It completes on the next cycle.
              done      <= 1'b1;
              fault_op  <= 1'b1;
              rdata_cap <= '0;
            end else begin
              state      <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= ex_data[ADDR_W-1:0];
              dmem_wdata <= store_data;
              cnt        <= '0;
              fault_op   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            rdata_cap <= dmem_rdata;
            dmem_req  <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            rdata_cap <= '0;
            dmem_req  <= 1'b0;
            done      <= 1'b1;
            fault_op  <= 1'b1;
            mem_fault <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Sticky misalignment flag, raised when a misaligned op is rejected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      align_fault <= 1'b0;
    else if ((state == IDLE) && stall_mem && misaligned)
      align_fault <= 1'b1;
  end
`else
  assign align_fault = 1'b0;
`endif

  // ---- MEM/WB stage boundary ----
  // MEM/WB register: insert a bubble while stalled; otherwise take the ALU
  // result or the captured load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data     <= '0;
      wb_RegWrite <= 1'b0;
      wb_addr     <= '0;
    end else if (stall_mem) begin
      wb_RegWrite <= 1'b0;
    end else begin
      wb_data     <= MemtoReg ? rdata_cap : ex_data;
      wb_RegWrite <= RegWrite & ~(done & fault_op);
      wb_addr     <= reg_write_addr;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: testbench for mem_stage_ctrl, built with TIMEOUT_CYCLES=4.
// It keeps a scoreboard of expected MEM/WB results and follows whether
// MEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage_ctrl;

  localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ex_data, store_data, dmem_rdata;
  logic        MemRead, MemWrite, MemtoReg, RegWrite, dmem_ack;
  logic [4:0]  reg_write_addr;
  logic        dmem_req, dmem_we, stall_mem, wb_RegWrite, mem_fault, align_fault;
  logic [63:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_addr;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .ex_data(ex_data), .store_data(store_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .reg_write_addr(reg_write_addr), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_mem(stall_mem), .wb_data(wb_data),
    .wb_RegWrite(wb_RegWrite), .wb_addr(wb_addr), .mem_fault(mem_fault),
    .align_fault(align_fault)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        rw;
    logic [4:0]  addr;
  } wb_t;

  wb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one EX/MEM op, act as the memory (ack in ACCESS cycle ack_at; 0 = never),
  // then compare the writeback against the scoreboard.
  task automatic do_op(input logic [63:0] ex, input logic [63:0] sd,
                       input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [4:0] dst, input int ack_at, input logic [63:0] rd);
    logic mop, mis, tmo;
    int   exp_stall, exp_acc, stalls, acc;
    wb_t  e, g;
    mop       = mr | mw;
    mis       = ALIGN_EN && mop && (ex[2:0] != 3'b000);
    tmo       = mop && !mis && ((ack_at == 0) || (ack_at > TO));
    exp_stall = !mop ? 0 : (mis ? 1 : (tmo ? 1 + TO : 1 + ack_at));
    exp_acc   = (!mop || mis) ? 0 : (tmo ? TO : ack_at);
    e.data    = m2r ? ((tmo || mis) ? 64'h0 : rd) : ex;
    e.rw      = rw & ~(tmo | mis);
    e.addr    = dst;
    sb.push_back(e);

    ex_data = ex; store_data = sd; MemRead = mr; MemWrite = mw;
    MemtoReg = m2r; RegWrite = rw; reg_write_addr = dst;
    stalls = 0; acc = 0;
    #1;
    while (stall_mem && (stalls < 50)) begin
      if (dmem_req) begin
        acc++;
        check("req_addr", dmem_addr, ex);
        check("req_we", {63'd0, dmem_we}, {63'd0, mw});
        check("req_wdata", dmem_wdata, sd);
        dmem_ack   = (acc == ack_at);
        dmem_rdata = (acc == ack_at) ? rd : 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        // A stray ack while no request is outstanding must be ignored.
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hFFFF_0000_FFFF_0000;
      end
      @(posedge clk); #1;
      stalls++;
      dmem_ack = 1'b0;
      check("bubble_wb_rw", {63'd0, wb_RegWrite}, 64'd0);
    end
    dmem_ack = 1'b0;
    check("stall_cycles", stalls, exp_stall);
    check("access_cycles", acc, exp_acc);
    check("req_idle", {63'd0, dmem_req}, 64'd0);
    @(posedge clk); #1;
    g = sb.pop_front();
    check("wb_data", wb_data, g.data);
    check("wb_rw", {63'd0, wb_RegWrite}, {63'd0, g.rw});
    check("wb_addr", {59'd0, wb_addr}, {59'd0, g.addr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; ex_data = '0; store_data = '0; MemRead = 0; MemWrite = 0;
    MemtoReg = 0; RegWrite = 0; reg_write_addr = '0; dmem_rdata = '0; dmem_ack = 0;

    // Hold reset while ack toggles. Every output must stay at 0.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dmem_ack = ~dmem_ack; dmem_rdata = 64'hABCD;
    end
    dmem_ack = 1'b0;
    check("rst_req", {63'd0, dmem_req}, 64'd0);
    check("rst_we", {63'd0, dmem_we}, 64'd0);
    check("rst_addr", dmem_addr, 64'd0);
    check("rst_wdata", dmem_wdata, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_wb_rw", {63'd0, wb_RegWrite}, 64'd0);
    check("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
    check("rst_mem_fault", {63'd0, mem_fault}, 64'd0);
    check("rst_align_fault", {63'd0, align_fault}, 64'd0);
    check("rst_stall", {63'd0, stall_mem}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_stall", {63'd0, stall_mem}, 64'd0);
    check("post_rst_req", {63'd0, dmem_req}, 64'd0);

    // ALU op: written back on the next edge with no memory request.
    do_op(64'h1234, 64'h0, 0, 0, 0, 1, 5'd5, 0, 64'h0);
    check("alu_no_req", {63'd0, dmem_req}, 64'd0);

    // Loads: ack in the first ACCESS cycle, then an ack delayed by 4 cycles.
    do_op(64'h40, 64'h0, 1, 0, 1, 1, 5'd3, 1, 64'hDEAD_BEEF);
    do_op(64'h40, 64'h0, 1, 0, 1, 1, 5'd7, 4, 64'h1122_3344_5566_7788);

    // A store, then a back-to-back load that must raise a fresh request.
    do_op(64'h80, 64'hAA, 0, 1, 0, 0, 5'd0, 2, 64'h0);
    do_op(64'h80, 64'h0, 1, 0, 1, 1, 5'd9, 1, 64'hAA);

    // MemRead and MemWrite both set: handled as a store.
    do_op(64'h100, 64'h55, 1, 1, 0, 0, 5'd0, 1, 64'h0);

    // Timeout: no ack. Writeback is suppressed and the fault flag sticks.
    check("fault_before_to", {63'd0, mem_fault}, 64'd0);
    do_op(64'h200, 64'h0, 1, 0, 1, 1, 5'd4, 0, 64'h0);
    check("fault_after_to", {63'd0, mem_fault}, 64'd1);
    do_op(64'h77, 64'h0, 0, 0, 0, 1, 5'd8, 0, 64'h0);
    check("fault_sticky", {63'd0, mem_fault}, 64'd1);

    // Misaligned load: rejected when the check is built in, issued otherwise.
    do_op(64'h43, 64'h0, 1, 0, 1, 1, 5'd6, 1, 64'h77);
    check("align_fault", {63'd0, align_fault}, {63'd0, ALIGN_EN});

    // Mixed aligned traffic.
    for (int i = 0; i < 6; i++) begin
      logic [63:0] a, d;
      a = {$urandom, $urandom} & ~64'h7;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0)
        do_op(a, 64'h0, 0, 0, 0, 1, 5'($urandom_range(1, 31)), 0, 64'h0);
      else
        do_op(a, 64'h0, 1, 0, 1, 1, 5'($urandom_range(1, 31)), int'($urandom_range(1, 3)), d);
    end

    // Reset pulse in the middle of an access drops the request asynchronously.
    ex_data = 64'h300; MemRead = 1; MemWrite = 0; MemtoReg = 1; RegWrite = 1;
    reg_write_addr = 5'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (dmem_req) break;
    end
    check("mid_req_seen", {63'd0, dmem_req}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req", {63'd0, dmem_req}, 64'd0);
    check("mid_rst_fault", {63'd0, mem_fault}, 64'd0);
    check("mid_rst_wb_rw", {63'd0, wb_RegWrite}, 64'd0);
    MemRead = 0; MemtoReg = 0; RegWrite = 0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_idle_stall", {63'd0, stall_mem}, 64'd0);
    check("mid_rst_idle_req", {63'd0, dmem_req}, 64'd0);

    // Recovery after the abandoned access.
    do_op(64'h308, 64'h0, 1, 0, 1, 1, 5'd12, 2, 64'hCAFE_F00D);
    check("sb_empty", sb.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
